arb_mux: RTL

Registered N-input multiplexer with per-channel valid/ready handshakes and a selectable arbitration mode. It generalises the combinational packed-bus mux with registered output, back-pressure, and either externally selected or round-robin channel choice. It sits between several producer streams and one consumer, for example funnelling DEPTH request queues into a shared datapath.

---
 rtl/mux_pkg.sv | 17 +
 rtl/rr_grant.sv | 40 ++++
 rtl/arb_mux.sv | 94 +++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the arb_mux block.
//   log2            : ceiling log2, returns 0 for an argument of 1
//   MUX_MODE_SELECT : arb_mux MODE value for externally selected channel
//   MUX_MODE_RR     : arb_mux MODE value for round-robin arbitration
package mux_pkg;

  localparam int MUX_MODE_SELECT = 0;
  localparam int MUX_MODE_RR     = 1;

  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin grant: first requesting channel at or above ptr,
// wrapping DEPTH-1 -> 0.
//   req   : per-channel request vector
//   ptr   : highest-priority channel this cycle
//   any   : at least one request present
//   grant : index of the winning channel (0 when any is low)
module rr_grant
  import mux_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int SEL_WIDTH = log2(DEPTH)
) (
  input  logic [DEPTH-1:0]     req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic                 any,
  output logic [SEL_WIDTH-1:0] grant
);

  // Two copies of req side by side; masking bits below ptr leaves the upper
  // copy to supply the wrapped-around candidates, so a plain lowest-set
  // search gives the rotated priority.
  logic [2*DEPTH-1:0] dreq;
  logic [2*DEPTH-1:0] masked;

  always_comb begin
    dreq   = {req, req};
    masked = '0;
    for (int j = 0; j < 2*DEPTH; j++)
      masked[j] = dreq[j] && (j >= int'(ptr));
  end

  // Descending scan: the last hit written is the lowest set index.
  always_comb begin
    any   = |req;
    grant = '0;
    for (int j = 2*DEPTH-1; j >= 0; j--)
      if (masked[j]) grant = SEL_WIDTH'(j % DEPTH);
  end

endmodule

// File: rtl/arb_mux.sv
// Registered N-input mux with per-channel valid/ready and a single output
// register stage. MODE selects external channel select or round-robin.
//   clk, rst  : clock, async active-high reset
//   dataIn    : DEPTH packed channels of BIT_WIDTH, channel i at [BIT_WIDTH*i +: BIT_WIDTH]
//   validIn   : per-channel valid
//   readyOut  : per-channel ready, combinational, one-hot or zero
//   select    : requested channel (select mode only)
//   muxout    : registered output data
//   validOut  : muxout holds an item
//   readyIn   : downstream accept
//   grant_id  : channel index of the item in muxout
module arb_mux
  import mux_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int DEPTH     = 8,
  parameter int SEL_WIDTH = log2(DEPTH),
  parameter int MODE      = MUX_MODE_SELECT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BIT_WIDTH*DEPTH-1:0] dataIn,
  input  logic [DEPTH-1:0]           validIn,
  output logic [DEPTH-1:0]           readyOut,
  input  logic [SEL_WIDTH-1:0]       select,
  output logic [BIT_WIDTH-1:0]       muxout,
  output logic                       validOut,
  input  logic                       readyIn,
  output logic [SEL_WIDTH-1:0]       grant_id
);

  logic [DEPTH-1:0][BIT_WIDTH-1:0] chan;
  logic                            any_req;
  logic [SEL_WIDTH-1:0]            grant;
  logic                            load;

  assign chan = dataIn;

  generate
    if (MODE == MUX_MODE_RR) begin : g_rr
      logic [SEL_WIDTH-1:0] ptr;
      logic                 rr_any;
      logic [SEL_WIDTH-1:0] rr_gnt;
      logic                 unused_select;

      assign unused_select = ^select;

      rr_grant #(.DEPTH(DEPTH), .SEL_WIDTH(SEL_WIDTH)) u_rr (
        .req   (validIn),
        .ptr   (ptr),
        .any   (rr_any),
        .grant (rr_gnt)
      );

      assign any_req = rr_any;
      assign grant   = rr_gnt;

      // Pointer advances past the winner only when an item is actually taken.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)       ptr <= '0;
        else if (load) ptr <= (int'(grant) == DEPTH-1) ? '0 : grant + 1'b1;
      end
    end else begin : g_sel
      // Out-of-range select is an idle request, never a grant.
      assign grant   = select;
      assign any_req = (int'(select) < DEPTH) && validIn[select];
    end
  endgenerate

  // Output register is free when empty or draining this edge.
  assign load = (!validOut || readyIn) && any_req;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
      assign readyOut[i] = !rst && load && (int'(grant) == i);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validOut <= 1'b0;
      muxout   <= '0;
      grant_id <= '0;
    end else if (load) begin
      muxout   <= chan[grant];
      grant_id <= grant;
      validOut <= 1'b1;
    end else if (readyIn) begin
      // Drain: data and id stay stale, only valid drops.
      validOut <= 1'b0;
    end
  end

endmodule
